ppu_spr_dma: RTL

PPU_SPR_DMA -- requirements
Module: ppu_spr_dma

---
 rtl/ppu_spr_dma.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ppu_spr_dma.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_spr_dma
//  Description : Sprite DMA engine. Snoops the CPU bus for a write to the DMA
//                trigger register. It then becomes a bus master and copies
//                256 bytes from page {wdata,8'hxx} to the OAM data register.
//                Each byte takes one read, one read-latency cycle and one
//                write.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_cpu_clk    in   1   sole clock
//    i_cpu_rst    in   1   synchronous active-high reset
//    i_bus_addr   in  16   snooped CPU bus address
//    i_bus_wn     in   1   snooped CPU write strobe (active-low)
//    i_bus_wdata  in   8   snooped CPU write data (source page)
//    o_spr_req    out  1   bus master request
//    i_spr_gnt    in   1   bus grant
//    o_spr_addr   out 16   master address
//    o_spr_wn     out  1   master write strobe (active-low)
//    o_spr_wdata  out  8   master write data
//    i_spr_rdata  in   8   master read data (one cycle after granted read)
//    o_busy       out  1   transfer in progress
//    o_done       out  1   one-cycle completion pulse
// ============================================================================
module ppu_spr_dma #(
  parameter logic [15:0] P_DMA_REG  = 16'h4014,
  parameter logic [15:0] P_OAM_DATA = 16'h2004
) (
  input  logic        i_cpu_clk,
  input  logic        i_cpu_rst,
  input  logic [15:0] i_bus_addr,
  input  logic        i_bus_wn,
  input  logic [7:0]  i_bus_wdata,
  output logic        o_spr_req,
  input  logic        i_spr_gnt,
  output logic [15:0] o_spr_addr,
  output logic        o_spr_wn,
  output logic [7:0]  o_spr_wdata,
  input  logic [7:0]  i_spr_rdata,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_LAT  = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] page;
  logic [7:0] page_nxt;
  logic [7:0] index;
  logic [7:0] index_nxt;
  logic [7:0] data;
  logic [7:0] data_nxt;
  logic       trigger;

  // CPU write to the DMA register; only acted upon while idle.
  assign trigger = (i_bus_addr == P_DMA_REG) && !i_bus_wn;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_cpu_clk) begin
    if (i_cpu_rst) begin
      state <= S_IDLE;
      page  <= 8'h00;
      index <= 8'h00;
      data  <= 8'h00;
    end else begin
      state <= state_nxt;
      page  <= page_nxt;
      index <= index_nxt;
      data  <= data_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode. The outputs depend only on the registered
  // state, page, index and data. No bus or grant input reaches an output
  // combinationally.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    page_nxt    = page;
    index_nxt   = index;
    data_nxt    = data;
    o_spr_req   = 1'b0;
    o_spr_addr  = {page, 8'h00};
    o_spr_wn    = 1'b1;
    o_spr_wdata = data;
    o_busy      = 1'b1;
    o_done      = 1'b0;

    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (trigger) begin
          page_nxt  = i_bus_wdata;
          index_nxt = 8'h00;
          state_nxt = S_REQ;
        end
      end

      S_REQ: begin
        o_spr_req = 1'b1;
        if (i_spr_gnt) begin
          state_nxt = S_RD;
        end
      end

      S_RD: begin
        o_spr_req  = 1'b1;
        o_spr_addr = {page, index};
        if (i_spr_gnt) begin
          state_nxt = S_LAT;
        end
      end

      // The read data returns one cycle after the granted address. It is
      // captured here whatever the grant is doing.
      S_LAT: begin
        o_spr_req  = 1'b1;
        o_spr_addr = {page, index};
        data_nxt   = i_spr_rdata;
        state_nxt  = S_WR;
      end

      S_WR: begin
        o_spr_req  = 1'b1;
        o_spr_addr = P_OAM_DATA;
        o_spr_wn   = 1'b0;
        if (i_spr_gnt) begin
          // The index never wraps. The last byte goes straight to DONE.
          if (index == 8'hFF) begin
            state_nxt = S_DONE;
          end else begin
            index_nxt = index + 8'd1;
            state_nxt = S_RD;
          end
        end
      end

      S_DONE: begin
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
